// File: rtl/mips_control_pipeline_track_pkg.sv
// Shared constants and predicates for the execute-side control tracking pipeline.
package mips_control_pipeline_track_pkg;

  // A bubble is an all-zero slot: not valid, no control bits set, no destination.
  localparam logic BUBBLE_FILL = 1'b0;

  function automatic int fwd_sel_w(input int stages);
    return $clog2(stages + 1);
  endfunction

  function automatic logic is_writer(input logic valid, input logic write_flag,
                                     input logic dest_nonzero);
    return valid & write_flag & dest_nonzero;
  endfunction

  function automatic logic src_match(input logic uses, input logic src_nonzero,
                                     input logic equal);
    return uses & src_nonzero & equal;
  endfunction

endpackage

// File: rtl/mips_control_pipeline_track_forward.sv
// Priority match of one source register against the tracked stages; the lowest stage wins.
module mips_control_pipeline_track_forward
  import mips_control_pipeline_track_pkg::*;
#(
  parameter int STAGES = 3,
  parameter int REG_W  = 5,
  parameter int SEL_W  = 2
) (
  input  logic [REG_W-1:0]        src,
  input  logic                    uses,
  input  logic [STAGES-1:0]       candidate,
  input  logic [STAGES*REG_W-1:0] dest,
  output logic [SEL_W-1:0]        sel
);

  logic [STAGES-1:0] hit;

  for (genvar s = 0; s < STAGES; s++) begin : g_hit
    assign hit[s] = candidate[s] &
                    src_match(uses, src != '0, dest[s*REG_W +: REG_W] == src);
  end

  // Walk from the oldest stage down so the youngest matching writer overrides.
  always_comb begin
    // NOTE: default first so every path assigns sel and no latch is inferred.
    sel = '0;
    for (int s = STAGES - 1; s >= 0; s--) begin
      if (hit[s]) sel = SEL_W'(s + 1);
    end
  end

endmodule

// File: rtl/mips_control_pipeline_track.sv
// Tracks decoded control words through EX..WB, with load-use bubbles, flush, hold and forwarding.
module mips_control_pipeline_track
  import mips_control_pipeline_track_pkg::*;
#(
  parameter int CONTROL_W   = 32,
  parameter int STAGES      = 3,
  parameter int REG_W       = 5,
  parameter int WRITE_BIT   = 0,
  parameter int LOAD_BIT    = 1,
  parameter int FLUSH_DEPTH = 1,
  parameter int COUNT_W     = 16
) (
  input  logic                            clock,
  input  logic                            resetN,
  input  logic                            inValid,
  input  logic [CONTROL_W-1:0]            inControl,
  input  logic [REG_W-1:0]                inDest,
  input  logic [REG_W-1:0]                inSrcA,
  input  logic [REG_W-1:0]                inSrcB,
  input  logic                            inUsesA,
  input  logic                            inUsesB,
  input  logic                            holdAll,
  input  logic                            flush,
  output logic                            inReady,
  output logic [STAGES-1:0]               stageValid,
  output logic [STAGES*CONTROL_W-1:0]     stageControl,
  output logic [STAGES*REG_W-1:0]         stageDest,
  output logic [fwd_sel_w(STAGES)-1:0]    forwardA,
  output logic [fwd_sel_w(STAGES)-1:0]    forwardB,
  output logic [COUNT_W-1:0]              bubbleCount
);

  localparam int SEL_W = fwd_sel_w(STAGES);

  logic [STAGES-1:0] writer;
  logic [STAGES-1:0] fwd_candidate;
  logic              load0;
  logic              hazard;

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    logic                 v_q, v_d;
    logic [CONTROL_W-1:0] c_q, c_d;
    logic [REG_W-1:0]     d_q, d_d;

    if (s == 0) begin : g_head
      always_comb begin
        v_d = inValid;
        c_d = inValid ? inControl : {CONTROL_W{BUBBLE_FILL}};
        d_d = inValid ? inDest : {REG_W{BUBBLE_FILL}};
        if (flush || hazard) begin
          v_d = BUBBLE_FILL;
          c_d = {CONTROL_W{BUBBLE_FILL}};
          d_d = {REG_W{BUBBLE_FILL}};
        end
      end
    end else begin : g_tail
      localparam bit IN_FLUSH = (s < FLUSH_DEPTH);
      always_comb begin
        v_d = stageValid[s-1];
        c_d = stageControl[(s-1)*CONTROL_W +: CONTROL_W];
        d_d = stageDest[(s-1)*REG_W +: REG_W];
        if (IN_FLUSH && flush) begin
          v_d = BUBBLE_FILL;
          c_d = {CONTROL_W{BUBBLE_FILL}};
          d_d = {REG_W{BUBBLE_FILL}};
        end
      end
    end

    // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
        v_q <= 1'b0;
        c_q <= '0;
        d_q <= '0;
      end else if (!holdAll) begin
        v_q <= v_d;
        c_q <= c_d;
        d_q <= d_d;
      end
    end

    assign stageValid[s]                           = v_q;
    assign stageControl[s*CONTROL_W +: CONTROL_W]  = c_q;
    assign stageDest[s*REG_W +: REG_W]             = d_q;
    assign writer[s] = is_writer(v_q, c_q[WRITE_BIT], d_q != '0);
  end

  assign load0 = stageControl[LOAD_BIT];

  // A load in EX has no result yet, so it can only cause a stall, never a forward.
  always_comb begin
    fwd_candidate    = writer;
    fwd_candidate[0] = writer[0] & ~load0;
  end

  assign hazard = inValid & writer[0] & load0 &
                  (src_match(inUsesA, inSrcA != '0, inSrcA == stageDest[REG_W-1:0]) |
                   src_match(inUsesB, inSrcB != '0, inSrcB == stageDest[REG_W-1:0]));

  assign inReady = !holdAll && (flush || !hazard);

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      bubbleCount <= '0;
    end else if (!holdAll && !flush && hazard && bubbleCount != '1) begin
      bubbleCount <= bubbleCount + COUNT_W'(1);
    end
  end

  mips_control_pipeline_track_forward #(
    .STAGES (STAGES),
    .REG_W  (REG_W),
    .SEL_W  (SEL_W)
  ) u_forward_a (
    .src       (inSrcA),
    .uses      (inUsesA),
    .candidate (fwd_candidate),
    .dest      (stageDest),
    .sel       (forwardA)
  );

  mips_control_pipeline_track_forward #(
    .STAGES (STAGES),
    .REG_W  (REG_W),
    .SEL_W  (SEL_W)
  ) u_forward_b (
    .src       (inSrcB),
    .uses      (inUsesB),
    .candidate (fwd_candidate),
    .dest      (stageDest),
    .sel       (forwardB)
  );

endmodule

// File: tb/tb_mips_control_pipeline_track.sv
// Scoreboard bench: stimulus queues expected observations, a monitor compares them on sample points.
module tb_mips_control_pipeline_track;

  localparam int CW = 32;
  localparam int RW = 5;
  localparam logic [31:0] LW  = 32'h0000_0103;
  localparam logic [31:0] ADD = 32'h0000_0201;
  localparam logic [31:0] BR  = 32'h0000_0400;

  logic           clock = 1'b0;
  logic           resetN;
  logic           inValid;
  logic [CW-1:0]  inControl;
  logic [RW-1:0]  inDest, inSrcA, inSrcB;
  logic           inUsesA, inUsesB, holdAll, flush;
  logic           inReady;
  logic [2:0]     stageValid;
  logic [3*CW-1:0] stageControl;
  logic [3*RW-1:0] stageDest;
  logic [1:0]     forwardA, forwardB;
  logic [1:0]     bubbleCount;

  mips_control_pipeline_track #(
    .CONTROL_W(CW), .STAGES(3), .REG_W(RW), .WRITE_BIT(0), .LOAD_BIT(1),
    .FLUSH_DEPTH(1), .COUNT_W(2)
  ) dut (
    .clock(clock), .resetN(resetN), .inValid(inValid), .inControl(inControl),
    .inDest(inDest), .inSrcA(inSrcA), .inSrcB(inSrcB), .inUsesA(inUsesA),
    .inUsesB(inUsesB), .holdAll(holdAll), .flush(flush), .inReady(inReady),
    .stageValid(stageValid), .stageControl(stageControl), .stageDest(stageDest),
    .forwardA(forwardA), .forwardB(forwardB), .bubbleCount(bubbleCount)
  );

  always #5 clock = ~clock;

  typedef enum {SIG_VALID, SIG_CTRL0, SIG_CTRL1, SIG_CTRL2, SIG_DEST,
                SIG_READY, SIG_FA, SIG_FB, SIG_BC} sig_e;
  typedef struct {
    sig_e        sig;
    logic [31:0] value;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  event sample_now;

  function automatic logic [31:0] observe(input sig_e s);
    case (s)
      SIG_VALID: return 32'(stageValid);
      SIG_CTRL0: return stageControl[0*CW +: CW];
      SIG_CTRL1: return stageControl[1*CW +: CW];
      SIG_CTRL2: return stageControl[2*CW +: CW];
      SIG_DEST:  return 32'(stageDest);
      SIG_READY: return 32'(inReady);
      SIG_FA:    return 32'(forwardA);
      SIG_FB:    return 32'(forwardB);
      default:   return 32'(bubbleCount);
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
  endtask

  initial begin : monitor
    forever begin
      @(negedge clock or sample_now);
      while (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        check(e.name, observe(e.sig), e.value);
      end
    end
  end

  task automatic exp_push(input sig_e s, input logic [31:0] v, input string n);
    exp_t e;
    e.sig = s; e.value = v; e.name = n;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] c, input logic [4:0] d,
                       input logic [4:0] a, input logic ua,
                       input logic [4:0] b, input logic ub);
    inValid = v; inControl = c; inDest = d;
    inSrcA = a; inUsesA = ua; inSrcB = b; inUsesB = ub;
  endtask

  logic [1:0] bc_model;

  initial begin : stim
    resetN = 1'b0; holdAll = 1'b0; flush = 1'b0;
    drive(1'b0, '0, '0, '0, 1'b0, '0, 1'b0);
    #1;
    exp_push(SIG_VALID, 0, "reset_valid");
    exp_push(SIG_BC,    0, "reset_bc");
    exp_push(SIG_READY, 1, "reset_ready");
    exp_push(SIG_FA,    0, "reset_fa");
    @(negedge clock);

    // Load-use: lw $5 then add reading $5.
    step(); resetN = 1'b1;
    drive(1'b1, LW, 5'd5, '0, 1'b0, '0, 1'b0);
    exp_push(SIG_READY, 1, "lw_ready");
    step(); drive(1'b1, ADD, 5'd6, 5'd5, 1'b1, 5'd3, 1'b1);
    exp_push(SIG_READY, 0, "lu_stall_ready");
    exp_push(SIG_FA,    0, "lu_stall_fa");
    step();
    exp_push(SIG_VALID, 32'b010, "lu_bubble_valid");
    exp_push(SIG_READY, 1, "lu_after_ready");
    exp_push(SIG_FA,    2, "lu_after_fa");
    exp_push(SIG_BC,    1, "lu_after_bc");
    step(); drive(1'b1, ADD, 5'd7, '0, 1'b0, '0, 1'b0);
    exp_push(SIG_VALID, 32'b101, "adv_valid");
    exp_push(SIG_DEST,  (5 << 10) | 6, "adv_dest");
    exp_push(SIG_CTRL0, ADD, "adv_ctrl0");
    exp_push(SIG_CTRL2, LW, "adv_ctrl2");

    // Forward priority: $7 writers in stages 0 and 2.
    step(); drive(1'b0, '0, '0, '0, 1'b0, '0, 1'b0);
    step(); drive(1'b1, 32'h0000_0211, 5'd7, '0, 1'b0, '0, 1'b0);
    step(); drive(1'b1, ADD, 5'd8, 5'd0, 1'b1, 5'd7, 1'b1);
    exp_push(SIG_VALID, 32'b101, "fwd_valid");
    exp_push(SIG_FB,    1, "fwd_b_youngest");
    exp_push(SIG_FA,    0, "fwd_a_reg0");
    step(); drive(1'b1, BR, 5'd0, 5'd7, 1'b1, 5'd0, 1'b1);
    exp_push(SIG_FA,    2, "fwd_a_stage1");
    exp_push(SIG_FB,    0, "fwd_b_reg0");

    // Flush with a branch in stage 0 and a valid decode.
    step(); drive(1'b1, ADD, 5'd9, '0, 1'b0, '0, 1'b0); flush = 1'b1;
    exp_push(SIG_READY, 1, "flush_ready");
    step(); flush = 1'b0; drive(1'b1, LW, 5'd4, '0, 1'b0, '0, 1'b0);
    exp_push(SIG_VALID, 32'b110, "flush_valid");
    exp_push(SIG_CTRL0, 0, "flush_ctrl0");
    exp_push(SIG_CTRL1, BR, "flush_ctrl1");
    exp_push(SIG_DEST,  8 << 10, "flush_dest");

    // Hold with simultaneous flush and hazard.
    step(); holdAll = 1'b1; flush = 1'b1;
    drive(1'b1, ADD, 5'd10, 5'd4, 1'b1, '0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      exp_push(SIG_READY, 0, "hold_ready");
      exp_push(SIG_VALID, 32'b101, "hold_valid");
      exp_push(SIG_CTRL0, LW, "hold_ctrl0");
      exp_push(SIG_BC,    1, "hold_bc");
      if (i < 2) step();
    end
    step(); holdAll = 1'b0;
    exp_push(SIG_READY, 1, "release_ready");
    exp_push(SIG_FA,    0, "release_fa_load");
    step(); flush = 1'b0; drive(1'b0, '0, '0, '0, 1'b0, '0, 1'b0);
    exp_push(SIG_VALID, 32'b010, "release_valid");
    exp_push(SIG_CTRL1, LW, "release_ctrl1");
    exp_push(SIG_BC,    1, "release_bc");

    // Saturation: five more load-use bubbles on a 2-bit counter.
    bc_model = 2'd1;
    for (int i = 0; i < 5; i++) begin
      step(); drive(1'b1, LW, 5'd5, '0, 1'b0, '0, 1'b0);
      exp_push(SIG_READY, 1, "sat_lw_ready");
      step(); drive(1'b1, ADD, 5'd6, 5'd5, 1'b1, '0, 1'b0);
      exp_push(SIG_READY, 0, "sat_stall_ready");
      step();
      bc_model = (bc_model == 2'd3) ? 2'd3 : bc_model + 2'd1;
      exp_push(SIG_READY, 1, "sat_after_ready");
      exp_push(SIG_FA,    2, "sat_after_fa");
      exp_push(SIG_BC,    32'(bc_model), "sat_bc");
    end

    // Fill all stages, then reset asynchronously between edges.
    step(); drive(1'b1, ADD, 5'd11, '0, 1'b0, '0, 1'b0);
    step(); drive(1'b1, ADD, 5'd12, '0, 1'b0, '0, 1'b0);
    step(); drive(1'b0, '0, '0, '0, 1'b0, '0, 1'b0);
    exp_push(SIG_VALID, 32'b111, "prereset_valid");
    @(negedge clock);
    #1 resetN = 1'b0;
    #1;
    exp_push(SIG_VALID, 0, "async_reset_valid");
    exp_push(SIG_BC,    0, "async_reset_bc");
    exp_push(SIG_READY, 1, "async_reset_ready");
    exp_push(SIG_DEST,  0, "async_reset_dest");
    -> sample_now;
    #1;
    resetN = 1'b1;

    @(negedge clock);
    @(negedge clock);
    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mips_control_pipeline_track.md
# Mips_Control_Pipeline_track

Carries the decoded control word of each issued instruction through the execute-side pipeline registers, which are parametrised in stage count. It detects load-use hazards and inserts bubbles, applies branch flushes and global holds, and produces per-operand forwarding selects. It sits between the decode-stage control generator and the execute/memory/writeback datapath, and is the sequential successor of the purely combinational control generation.

## Interface
Parameters:
- CONTROL_W, 32, width of one control word
- STAGES, 3, number of tracked stages; stage 0 = EX, stage STAGES-1 = WB
- REG_W, 5, register index width
- WRITE_BIT, 0, control-word bit meaning "writes register file"
- LOAD_BIT, 1, control-word bit meaning "load from memory"
- FLUSH_DEPTH, 1, number of youngest stages that load a bubble on flush (1..STAGES)
- COUNT_W, 16, bubble counter width

Ports:
- clock  in  1  single clock, rising edge
- resetN  in  1  asynchronous, active-low reset
- inValid  in  1  decode holds an instruction
- inControl  in  CONTROL_W  decoded control word
- inDest  in  REG_W  destination register
- inSrcA, inSrcB  in  REG_W  source registers
- inUsesA, inUsesB  in  1  source actually read
- holdAll  in  1  external stall; freezes every stage
- flush  in  1  branch redirect
- inReady  out  1  decode instruction accepted this cycle
- stageValid  out  STAGES  per-stage valid, stage 0 at bit 0
- stageControl  out  STAGES*CONTROL_W  per-stage control, stage 0 at LSBs
- stageDest  out  STAGES*REG_W  per-stage destination
- forwardA, forwardB  out  $clog2(STAGES+1)  0 = register file; k = result of stage k-1
- bubbleCount  out  COUNT_W  saturating count of hazard bubbles

## Operation
- Reset (resetN=0, async): every stageValid, stageControl, stageDest and bubbleCount is 0. Combinational outputs then read inReady=!holdAll and forwardA=forwardB=0.
- "Writer" in stage s: valid, control[WRITE_BIT]=1, dest≠0.
- Hazard: inValid & stage 0 is a writer with control[LOAD_BIT]=1 & ((inUsesA & inSrcA==dest0) | (inUsesB & inSrcB==dest0)).
- Per-edge priority:
  1. holdAll=1: all registers hold; flush and hazard are ignored; inReady=0. A flush must be held by its source until holdAll=0.
  2. flush=1: stages 0..FLUSH_DEPTH-1 load a bubble (valid=0, control=0, dest=0). Stages ≥FLUSH_DEPTH load their upstream. The decode instruction is discarded and inReady=1.
  3. hazard=1: stage 0 loads a bubble, stages ≥1 advance, inReady=0, and bubbleCount increments, saturating at all-ones.
  4. Otherwise: stage 0 loads {inValid, inControl, inDest}, gated to zeros when inValid=0. Stages ≥1 advance and inReady=1.
- Forwarding, per operand and combinational: select the lowest-index writer stage whose dest equals the source. Stage 0 is excluded when it is a load. Output s+1, or 0 if there is no match or the source is register 0. An unused operand (inUsesX=0) yields 0.
- A bubble never matches for forwarding or hazard.

## Timing
- Stage latency is 1 cycle per stage. An instruction accepted at edge n is in stage k after edge n+k, absent holds.
- inReady, forwardA, forwardB and the hazard term are combinational from inputs and current state, with no added latency.
- A load-use pair costs exactly one bubble. On the next cycle the load sits in stage 1, hazard=0, and forwarding selects 2.
- Mid-operation reset clears all stages immediately, without waiting for a clock edge.
- bubbleCount does not wrap; it holds at 2^COUNT_W-1.

## Structure
- Package Mips_Control_Pipeline holds the bubble constant, the forward-select width function, and the writer/match predicates.
- Sub-module Mips_Control_Pipeline_forward is a priority match over stages for one source. It is instantiated twice, once for A and once for B.
- The stage registers form a generate loop over STAGES.

## Test plan
- Reset: drive resetN low mid-stream with 3 valid stages → all stageValid=0, bubbleCount=0, and inReady=1 with no clock edge.
- Load-use: lw $5 in stage 0, decode add reading $5 → inReady=0 and stage 0 becomes a bubble next cycle. On the following cycle inReady=1 with forwardA=2 and bubbleCount=1.
- Forward priority: writers to $7 in stages 0 (non-load) and 2, decode reads $7 on B → forwardB=1. A source of $0 gives forwardB=0.
- Flush with FLUSH_DEPTH=1: branch in stage 0 plus valid decode, flush=1 → next stage0 is a bubble, the branch moves to stage 1, and the decode instruction is dropped.
- holdAll with simultaneous flush and hazard: three edges of holdAll=1 → all stages unchanged, inReady=0, bubbleCount unchanged. Releasing holdAll with flush still high applies the flush.
- Saturation with COUNT_W=2: five hazard bubbles → bubbleCount=3.
